// File: rtl/battle_pkg.sv
// Shared definitions for the battle screen.
// Holds the 4-bit phase codes broadcast on the state bus (menu, attack-bar,
// dialogue, mercy and bullet blocks decode these), the sequencer FSM state
// enum, the HP width, and small helpers for code lookup and saturating HP math.
package battle_pkg;

  localparam int HP_W = 8;

  localparam logic [3:0] ST_MENU   = 4'b0000;
  localparam logic [3:0] ST_ATTACK = 4'b0001;
  localparam logic [3:0] ST_ACT    = 4'b0010;
  localparam logic [3:0] ST_TALK   = 4'b0011;
  localparam logic [3:0] ST_MERCY  = 4'b0100;
  localparam logic [3:0] ST_DODGE  = 4'b0101;
  localparam logic [3:0] ST_WIN    = 4'b0110;
  localparam logic [3:0] ST_LOSE   = 4'b0111;
  localparam logic [3:0] ST_IDLE   = 4'b1010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_GAP    = 4'd1,
    S_MENU   = 4'd2,
    S_ATTACK = 4'd3,
    S_ACT    = 4'd4,
    S_TALK   = 4'd5,
    S_MERCY  = 4'd6,
    S_DODGE  = 4'd7,
    S_WIN    = 4'd8,
    S_LOSE   = 4'd9
  } fsm_e;

  // Bus code shown while the FSM sits in a given state.
  function automatic logic [3:0] phase_code(input fsm_e s);
    logic [3:0] c;
    case (s)
      S_MENU:   c = ST_MENU;
      S_ATTACK: c = ST_ATTACK;
      S_ACT:    c = ST_ACT;
      S_TALK:   c = ST_TALK;
      S_MERCY:  c = ST_MERCY;
      S_DODGE:  c = ST_DODGE;
      S_WIN:    c = ST_WIN;
      S_LOSE:   c = ST_LOSE;
      default:  c = ST_IDLE;
    endcase
    return c;
  endfunction

  // a - b clamped at zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                               input logic [HP_W-1:0] b);
    logic [HP_W-1:0] r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = {HP_W{1'b0}};
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle watchdog.
// Counts enabled cycles since the last clear; expire_out is high during the
// cycle whose count equals TIMEOUT-1 (the caller registers it).
// Ports: clk, rst (sync, active-high), clear_in, enable_in, expire_out.
module phase_watchdog #(
  parameter int TIMEOUT = 32500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  input  logic enable_in,
  output logic expire_out
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          expire_s;

  // Next count: clear wins, then wrap on expiry, otherwise count while enabled.
  always_comb begin
    expire_s = enable_in && (cnt_q == CW'(TIMEOUT - 1));
    cnt_d    = cnt_q;
    if (clear_in || expire_s) begin
      cnt_d = {CW{1'b0}};
    end else if (enable_in) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_out = expire_s;

endmodule

// File: rtl/battle_sequencer.sv
// Battle screen turn controller.
// Sequences MENU -> chosen action -> DODGE -> MENU, with every phase change
// passing through an IDLE gap so sub-blocks always see a fresh state edge.
// Tracks player/enemy HP, counts turns and guards each action phase with a
// watchdog.
// Ports: clk, rst (sync, active-high); start/finished pulses and their data
// from the sub-blocks; outputs state_out, player_hp_out, enemy_hp_out,
// turn_count_out, timeout_out, game_over_out (all registered).
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int PLAYER_HP     = 20,
  parameter int ENEMY_HP      = 100,
  parameter int HIT_DAMAGE    = 4,
  parameter int PHASE_TIMEOUT = 32500000,
  parameter int GAP_CYCLES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            menu_finished_in,
  input  logic [3:0]      menu_choice_in,
  input  logic            attack_finished_in,
  input  logic [HP_W-1:0] attack_damage_in,
  input  logic            act_finished_in,
  input  logic            talk_finished_in,
  input  logic            mercy_finished_in,
  input  logic            mercy_spare_in,
  input  logic            dodge_finished_in,
  input  logic            hit_in,
  output logic [3:0]      state_out,
  output logic [HP_W-1:0] player_hp_out,
  output logic [HP_W-1:0] enemy_hp_out,
  output logic [7:0]      turn_count_out,
  output logic            timeout_out,
  output logic            game_over_out
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  fsm_e            fsm_q, fsm_d, next_q, next_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      state_q, state_d;
  logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d;
  logic [7:0]      turn_q, turn_d;
  logic            timeout_q, timeout_d, over_q, over_d;
  logic            wd_active_s, wd_expire_s;
  logic            leave_s;
  fsm_e            target_s;
  logic [HP_W-1:0] hp_after_s;

  assign wd_active_s = (fsm_q == S_ATTACK) || (fsm_q == S_ACT) || (fsm_q == S_TALK) ||
                       (fsm_q == S_MERCY)  || (fsm_q == S_DODGE);

  // Cleared whenever no action phase is live, so each entry starts from zero.
  phase_watchdog #(.TIMEOUT(PHASE_TIMEOUT)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear_in   (!wd_active_s),
    .enable_in  (wd_active_s),
    .expire_out (wd_expire_s)
  );

  // Next-state and output computation.
  always_comb begin
    fsm_d      = fsm_q;
    next_d     = next_q;
    gap_d      = gap_q;
    state_d    = state_q;
    php_d      = php_q;
    ehp_d      = ehp_q;
    turn_d     = turn_q;
    over_d     = over_q;
    timeout_d  = wd_expire_s;
    leave_s    = 1'b0;
    target_s   = S_MENU;
    hp_after_s = {HP_W{1'b0}};

    case (fsm_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_in) begin
          php_d   = HP_W'(PLAYER_HP);
          ehp_d   = HP_W'(ENEMY_HP);
          turn_d  = 8'd0;
          over_d  = 1'b0;
          leave_s = 1'b1;
        end else begin
          leave_s = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          fsm_d   = next_q;
          state_d = phase_code(next_q);
          gap_d   = {GW{1'b0}};
          if (next_q == S_DODGE && turn_q != 8'hFF) begin
            turn_d = turn_q + 8'd1;
          end else begin
            turn_d = turn_q;
          end
          if (next_q == S_WIN || next_q == S_LOSE) begin
            over_d = 1'b1;
          end else begin
            over_d = over_q;
          end
        end else begin
          gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
        end
      end
      S_MENU: begin
        if (menu_finished_in) begin
          leave_s = 1'b1;
          if (menu_choice_in[3]) begin
            target_s = S_ATTACK;
          end else if (menu_choice_in[2]) begin
            target_s = S_ACT;
          end else if (menu_choice_in[1]) begin
            target_s = S_TALK;
          end else if (menu_choice_in[0]) begin
            target_s = S_MERCY;
          end else begin
            target_s = S_MENU;
          end
        end else begin
          leave_s = 1'b0;
        end
      end
      S_ATTACK: begin
        // A watchdog finish deals no damage; enemy HP is nonzero here, so DODGE.
        if (wd_expire_s) begin
          leave_s  = 1'b1;
          target_s = S_DODGE;
        end else if (attack_finished_in) begin
          hp_after_s = sat_sub(ehp_q, attack_damage_in);
          ehp_d      = hp_after_s;
          leave_s    = 1'b1;
          if (hp_after_s == {HP_W{1'b0}}) begin
            target_s = S_WIN;
          end else begin
            target_s = S_DODGE;
          end
        end else begin
          leave_s = 1'b0;
        end
      end
      S_ACT: begin
        leave_s  = wd_expire_s || act_finished_in;
        target_s = S_DODGE;
      end
      S_TALK: begin
        leave_s  = wd_expire_s || talk_finished_in;
        target_s = S_DODGE;
      end
      S_MERCY: begin
        leave_s = wd_expire_s || mercy_finished_in;
        if (!wd_expire_s && mercy_spare_in) begin
          target_s = S_WIN;
        end else begin
          target_s = S_DODGE;
        end
      end
      S_DODGE: begin
        // Hit is applied before finish so a lethal hit beats a simultaneous finish.
        if (wd_expire_s) begin
          leave_s  = 1'b1;
          target_s = S_MENU;
        end else if (hit_in) begin
          hp_after_s = sat_sub(php_q, HP_W'(HIT_DAMAGE));
          php_d      = hp_after_s;
          if (hp_after_s == {HP_W{1'b0}}) begin
            leave_s  = 1'b1;
            target_s = S_LOSE;
          end else begin
            leave_s  = dodge_finished_in;
            target_s = S_MENU;
          end
        end else begin
          leave_s  = dodge_finished_in;
          target_s = S_MENU;
        end
      end
      default: begin
        fsm_d   = S_IDLE;
        state_d = ST_IDLE;
      end
    endcase

    if (leave_s) begin
      fsm_d   = S_GAP;
      next_d  = target_s;
      gap_d   = {GW{1'b0}};
      state_d = ST_IDLE;
    end else begin
      next_d = next_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      next_q    <= S_MENU;
      gap_q     <= {GW{1'b0}};
      state_q   <= ST_IDLE;
      php_q     <= HP_W'(PLAYER_HP);
      ehp_q     <= HP_W'(ENEMY_HP);
      turn_q    <= 8'd0;
      timeout_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      next_q    <= next_d;
      gap_q     <= gap_d;
      state_q   <= state_d;
      php_q     <= php_d;
      ehp_q     <= ehp_d;
      turn_q    <= turn_d;
      timeout_q <= timeout_d;
      over_q    <= over_d;
    end
  end

  assign state_out      = state_q;
  assign player_hp_out  = php_q;
  assign enemy_hp_out   = ehp_q;
  assign turn_count_out = turn_q;
  assign timeout_out    = timeout_q;
  assign game_over_out  = over_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a phase-level model.
module tb_battle_sequencer;

  localparam int PHP = 20;
  localparam int EHP = 100;
  localparam int HIT = 4;
  localparam int TO  = 16;
  localparam int GAP = 2;

  localparam int C_MENU = 0, C_ATTACK = 1, C_ACT = 2, C_TALK = 3, C_MERCY = 4;
  localparam int C_DODGE = 5, C_WIN = 6, C_LOSE = 7, C_IDLE = 10;

  logic       clk = 1'b0;
  logic       rst, start_in, menu_finished_in, attack_finished_in;
  logic [3:0] menu_choice_in;
  logic [7:0] attack_damage_in;
  logic       act_finished_in, talk_finished_in, mercy_finished_in, mercy_spare_in;
  logic       dodge_finished_in, hit_in;
  logic [3:0] state_out;
  logic [7:0] player_hp_out, enemy_hp_out, turn_count_out;
  logic       timeout_out, game_over_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: what the bus shows, plus a countdown while a gap is pending.
  int m_code, m_target, m_gap_left, m_wd, m_php, m_ehp, m_turns, m_timeout, m_over;

  battle_sequencer #(
    .PLAYER_HP(PHP), .ENEMY_HP(EHP), .HIT_DAMAGE(HIT),
    .PHASE_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .menu_finished_in(menu_finished_in), .menu_choice_in(menu_choice_in),
    .attack_finished_in(attack_finished_in), .attack_damage_in(attack_damage_in),
    .act_finished_in(act_finished_in), .talk_finished_in(talk_finished_in),
    .mercy_finished_in(mercy_finished_in), .mercy_spare_in(mercy_spare_in),
    .dodge_finished_in(dodge_finished_in), .hit_in(hit_in),
    .state_out(state_out), .player_hp_out(player_hp_out),
    .enemy_hp_out(enemy_hp_out), .turn_count_out(turn_count_out),
    .timeout_out(timeout_out), .game_over_out(game_over_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic m_leave(input int t);
    m_code     = C_IDLE;
    m_target   = t;
    m_gap_left = GAP;
  endtask

  task automatic model_step();
    int v;
    m_timeout = 0;
    if (rst) begin
      m_code = C_IDLE; m_target = C_MENU; m_gap_left = 0; m_wd = 0;
      m_php = PHP; m_ehp = EHP; m_turns = 0; m_over = 0;
      return;
    end
    if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_code = m_target;
        m_wd   = 0;
        if (m_code == C_DODGE && m_turns < 255) m_turns++;
        if (m_code == C_WIN || m_code == C_LOSE) m_over = 1;
      end
      return;
    end
    if (m_code == C_IDLE || m_code == C_WIN || m_code == C_LOSE) begin
      if (start_in) begin
        m_php = PHP; m_ehp = EHP; m_turns = 0; m_over = 0;
        m_leave(C_MENU);
      end
      return;
    end
    if (m_code != C_MENU) begin
      if (m_wd == TO - 1) begin
        m_timeout = 1;
        m_leave((m_code == C_DODGE) ? C_MENU : C_DODGE);
        return;
      end
      m_wd++;
    end
    case (m_code)
      C_MENU: if (menu_finished_in) begin
        if (menu_choice_in[3]) m_leave(C_ATTACK);
        else if (menu_choice_in[2]) m_leave(C_ACT);
        else if (menu_choice_in[1]) m_leave(C_TALK);
        else if (menu_choice_in[0]) m_leave(C_MERCY);
        else m_leave(C_MENU);
      end
      C_ATTACK: if (attack_finished_in) begin
        v = m_ehp - int'(attack_damage_in);
        m_ehp = (v < 0) ? 0 : v;
        m_leave((m_ehp == 0) ? C_WIN : C_DODGE);
      end
      C_ACT:   if (act_finished_in) m_leave(C_DODGE);
      C_TALK:  if (talk_finished_in) m_leave(C_DODGE);
      C_MERCY: if (mercy_finished_in) m_leave(mercy_spare_in ? C_WIN : C_DODGE);
      C_DODGE: begin
        if (hit_in) begin
          v = m_php - HIT;
          m_php = (v < 0) ? 0 : v;
        end
        if (m_php == 0) m_leave(C_LOSE);
        else if (dodge_finished_in) m_leave(C_MENU);
      end
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    start_in = 0; menu_finished_in = 0; menu_choice_in = 4'b0000;
    attack_finished_in = 0; attack_damage_in = 8'd0;
    act_finished_in = 0; talk_finished_in = 0; mercy_finished_in = 0;
    mercy_spare_in = 0; dodge_finished_in = 0; hit_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("state", state_out, m_code);
    check("player_hp", player_hp_out, m_php);
    check("enemy_hp", enemy_hp_out, m_ehp);
    check("turns", turn_count_out, m_turns);
    check("timeout", timeout_out, m_timeout);
    check("game_over", game_over_out, m_over);
  endtask

  // Apply whatever pulse the caller set up, then ride out the gap.
  task automatic pulse_gap();
    tick();
    clear_inputs();
    for (int i = 0; i < GAP; i++) tick();
  endtask

  task automatic restart();
    start_in = 1;
    pulse_gap();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    check("rst_state", state_out, C_IDLE);
    check("rst_php", player_hp_out, PHP);
    rst = 0;
    tick();

    // Start: IDLE for GAP cycles, then MENU.
    start_in = 1;
    tick();
    clear_inputs();
    check("start_gap1", state_out, C_IDLE);
    tick();
    check("start_gap2", state_out, C_IDLE);
    tick();
    check("start_menu", state_out, C_MENU);
    check("start_ehp", enemy_hp_out, EHP);

    // Attack 30 -> enemy 70 -> DODGE -> MENU.
    menu_finished_in = 1; menu_choice_in = 4'b1000;
    pulse_gap();
    check("attack_state", state_out, C_ATTACK);
    attack_finished_in = 1; attack_damage_in = 8'd30;
    tick();
    clear_inputs();
    check("attack_ehp", enemy_hp_out, 70);
    for (int i = 0; i < GAP; i++) tick();
    check("dodge_state", state_out, C_DODGE);
    check("dodge_turns", turn_count_out, 1);
    dodge_finished_in = 1;
    pulse_gap();
    check("back_menu", state_out, C_MENU);

    // ACT, then five hits -> LOSE.
    menu_finished_in = 1; menu_choice_in = 4'b0100;
    pulse_gap();
    act_finished_in = 1;
    pulse_gap();
    hit_in = 1;
    for (int i = 0; i < 5; i++) tick();
    clear_inputs();
    for (int i = 0; i < GAP; i++) tick();
    check("lose_state", state_out, C_LOSE);
    check("lose_over", game_over_out, 1);

    // Hit together with finish at hp=4 -> LOSE, not MENU.
    restart();
    menu_finished_in = 1; menu_choice_in = 4'b0010;
    pulse_gap();
    talk_finished_in = 1;
    pulse_gap();
    hit_in = 1;
    for (int i = 0; i < 4; i++) tick();
    check("hp_four", player_hp_out, 4);
    hit_in = 1; dodge_finished_in = 1;
    pulse_gap();
    check("hit_finish_lose", state_out, C_LOSE);

    // Attack kills -> WIN.
    restart();
    menu_finished_in = 1; menu_choice_in = 4'b1111;
    pulse_gap();
    attack_finished_in = 1; attack_damage_in = 8'd30;
    pulse_gap();
    dodge_finished_in = 1;
    pulse_gap();
    menu_finished_in = 1; menu_choice_in = 4'b1000;
    pulse_gap();
    attack_finished_in = 1; attack_damage_in = 8'd200;
    pulse_gap();
    check("win_ehp", enemy_hp_out, 0);
    check("win_state", state_out, C_WIN);

    // Mercy spare -> WIN.
    restart();
    menu_finished_in = 1; menu_choice_in = 4'b0001;
    pulse_gap();
    mercy_finished_in = 1; mercy_spare_in = 1;
    pulse_gap();
    check("spare_win", state_out, C_WIN);

    // TALK never finishes; stray attack pulse ignored; watchdog forces DODGE.
    restart();
    menu_finished_in = 1; menu_choice_in = 4'b0010;
    pulse_gap();
    for (int i = 2; i <= TO; i++) begin
      if (i == 5) begin attack_finished_in = 1; attack_damage_in = 8'd50; end
      tick();
      clear_inputs();
    end
    check("talk_hold", state_out, C_TALK);
    check("stray_ehp", enemy_hp_out, EHP);
    tick();
    check("timeout_pulse", timeout_out, 1);
    check("timeout_gap", state_out, C_IDLE);
    tick();
    check("timeout_once", timeout_out, 0);
    tick();
    check("timeout_dodge", state_out, C_DODGE);

    // Empty choice re-enters MENU through a gap; then reset mid-DODGE.
    dodge_finished_in = 1;
    pulse_gap();
    menu_finished_in = 1; menu_choice_in = 4'b0000;
    tick();
    clear_inputs();
    check("empty_gap", state_out, C_IDLE);
    for (int i = 0; i < GAP; i++) tick();
    check("empty_menu", state_out, C_MENU);
    menu_finished_in = 1; menu_choice_in = 4'b0100;
    pulse_gap();
    act_finished_in = 1;
    pulse_gap();
    hit_in = 1;
    tick();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_state", state_out, C_IDLE);
    check("mid_rst_php", player_hp_out, PHP);
    check("mid_rst_turns", turn_count_out, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst                = ($urandom_range(0, 599) == 0);
      start_in           = ($urandom_range(0, 7) == 0);
      menu_finished_in   = ($urandom_range(0, 4) == 0);
      menu_choice_in     = 4'($urandom_range(0, 15));
      attack_finished_in = ($urandom_range(0, 7) == 0);
      attack_damage_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255))
                                                       : 8'($urandom_range(0, 40));
      act_finished_in    = ($urandom_range(0, 7) == 0);
      talk_finished_in   = ($urandom_range(0, 7) == 0);
      mercy_finished_in  = ($urandom_range(0, 7) == 0);
      mercy_spare_in     = ($urandom_range(0, 2) == 0);
      dodge_finished_in  = ($urandom_range(0, 7) == 0);
      hit_in             = ($urandom_range(0, 4) == 0);
      tick();
    end
    clear_inputs();
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/battle_sequencer.md
Name: battle_sequencer

Overview:
Top-level turn controller for the battle screen. Drives the 4-bit state bus read by the menu, attack-bar, act/talk dialogue, mercy and bullet-dodge blocks. Collects each block's one-cycle finished pulse and tracks player and enemy HP. Sequences MENU -> chosen action -> DODGE -> MENU until a win or lose condition, with a per-phase watchdog.

Parameters:
PLAYER_HP, 20, player HP loaded on start (8-bit).
ENEMY_HP, 100, enemy HP loaded on start (8-bit).
HIT_DAMAGE, 4, HP removed from player per hit_in pulse.
PHASE_TIMEOUT, 32500000, maximum cycles in any non-MENU active phase.
GAP_CYCLES, 2, cycles state_out holds IDLE between phases (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_in  in  1  pulse: begin new battle
menu_finished_in  in  1  pulse from menu
menu_choice_in  in  4  one-hot selection {attack,act,talk,mercy}, valid with menu_finished_in
attack_finished_in  in  1  pulse from attack bar
attack_damage_in  in  8  damage, valid with attack_finished_in
act_finished_in  in  1  pulse
talk_finished_in  in  1  pulse
mercy_finished_in  in  1  pulse
mercy_spare_in  in  1  spare granted, valid with mercy_finished_in
dodge_finished_in  in  1  pulse from bullet block
hit_in  in  1  pulse per player hit during DODGE
state_out  out  4  phase code broadcast to sub-blocks
player_hp_out  out  8  current player HP
enemy_hp_out  out  8  current enemy HP
turn_count_out  out  8  completed DODGE entries, saturating
timeout_out  out  1  one-cycle pulse on watchdog expiry
game_over_out  out  1  high in WIN or LOSE

Behaviour:
- State codes: MENU 0000, ATTACK 0001, ACT 0010, TALK 0011, MERCY 0100, DODGE 0101, WIN 0110, LOSE 0111, IDLE 1010.
- FSM states: S_IDLE, S_GAP, S_MENU, S_ATTACK, S_ACT, S_TALK, S_MERCY, S_DODGE, S_WIN, S_LOSE. The next-phase register is held during S_GAP.
- Reset values: state_out=1010; player_hp_out=PLAYER_HP; enemy_hp_out=ENEMY_HP; turn_count_out=0; timeout_out=0; game_over_out=0; FSM=S_IDLE; watchdog=0.
- S_IDLE: on start_in, reload HP, clear turn count, go to S_GAP with next=MENU. start_in is ignored outside S_IDLE, S_WIN and S_LOSE.
- Every phase change passes through S_GAP. A finished pulse at cycle N gives state_out=1010 from N+1 through N+GAP_CYCLES, then the new code at N+GAP_CYCLES+1. Sub-blocks start on the state edge, so re-entering the same phase always produces a fresh edge.
- S_MENU: on menu_finished_in, pick the next phase by priority bit3>bit2>bit1>bit0 (ATTACK, ACT, TALK, MERCY). A choice of 0000 returns to MENU via S_GAP. MENU has no watchdog.
- S_ATTACK finish: enemy_hp -= attack_damage_in, saturating at 0, registered the same edge. If the result is 0, next=WIN; else next=DODGE.
- S_ACT / S_TALK finish: next=DODGE.
- S_MERCY finish: if mercy_spare_in, next=WIN; else next=DODGE.
- S_DODGE: each hit_in does player_hp -= HIT_DAMAGE, saturating at 0.
  - When player_hp reaches 0, go immediately to S_GAP with next=LOSE, regardless of finish.
  - If hit_in and dodge_finished_in arrive together, the hit is applied first; LOSE takes precedence over MENU.
  - On normal finish, next=MENU.
- turn_count increments on entry to S_DODGE and saturates at 255.
- Watchdog counts cycles in ATTACK/ACT/TALK/MERCY/DODGE and clears on every phase entry. At count == PHASE_TIMEOUT-1 it pulses timeout_out for one cycle and forces a finish with zero effect: attack damage 0, spare 0, no HP change.
- Finished pulses not belonging to the current phase are ignored, including any pulse during S_GAP.
- hit_in outside S_DODGE is ignored.
- S_WIN / S_LOSE: state_out holds its code and game_over_out=1. start_in restarts exactly as from S_IDLE.
- rst at any point returns all outputs to reset values on the next edge, including mid-GAP or mid-DODGE.

Decomposition:
- Package battle_pkg: the state-code localparams (shared with menu and the other sub-blocks), an enum for FSM states, and the HP width constant.
- One sub-module, phase_watchdog: a parameterised counter with clear, enable and an expire pulse.

Test Plan:
1. rst, start_in -> state_out 1010 for 2 cycles then 0000; HP 20/100.
2. MENU finish choice 1000, attack_damage 30 -> ATTACK, then enemy_hp 70, state DODGE, turn_count 1; dodge finish -> MENU.
3. DODGE with 5 hit_in pulses (HIT_DAMAGE=4) -> player_hp 0, LOSE (0111), game_over 1. Also: hit_in with dodge_finished_in simultaneously at hp=4 -> LOSE, not MENU.
4. Attack damage 200 at enemy_hp 70 -> enemy_hp 0, WIN (0110). Separately: MERCY finish with spare=1 -> WIN.
5. PHASE_TIMEOUT=16, TALK never finishes -> timeout_out pulse at cycle 16 of TALK, then GAP, then DODGE. A stray attack_finished_in during TALK is ignored.
6. menu_choice 0000 -> IDLE gap then 0000 again (fresh edge). rst mid-DODGE -> all outputs at reset values next cycle.
